pulse_gen_multi: RTL

Multi-lane successor to the single-channel transducer pulser: one `i_sync` rising edge launches up to NCH independent HI/GND/LO/GND bursts. Each lane has its own start delay, enable and starting polarity; all lanes share timing from a shadow register latched at sync. The block adds burst-complete reporting and selectable retrigger behaviour. It sits in the 200 MHz `hi_clk` domain and drives the per-element znd switch outputs directly.

---
 rtl/pulse_gen_pkg.sv | 59 +++++
 rtl/pulse_gen_lane.sv | 112 +++++++++++
 rtl/pulse_gen_multi.sv | 115 +++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared types for the multi-lane transducer pulser.
//   - DEF_* : build widths; pulse_gen_multi parameters default to these
//   - lane_state_e : per-lane FSM state (3-bit, IDLE=0 .. HUSH=6)
//   - shadow_cfg_t : burst timing latched at the accepted sync edge
//   - znd_out_t / decode_lane : switch-drive decode of one lane's state
package pulse_gen_pkg;

  localparam int unsigned DEF_NCH    = 4;
  localparam int unsigned DEF_LEN_W  = 8;
  localparam int unsigned DEF_CNT_W  = 4;
  localparam int unsigned DEF_HUSH_W = 16;
  localparam int unsigned DEF_DLY_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_P1     = 3'd2,
    ST_P1_GND = 3'd3,
    ST_P2     = 3'd4,
    ST_P2_GND = 3'd5,
    ST_HUSH   = 3'd6
  } lane_state_e;

  // Timing shared by all lanes; per-lane enable/polarity/delay live beside it.
  typedef struct packed {
    logic [DEF_LEN_W-1:0]  hit_len;
    logic [DEF_LEN_W-1:0]  gnd_len;
    logic [DEF_CNT_W-1:0]  pulse_count;
    logic [DEF_HUSH_W-1:0] hush_len;
  } shadow_cfg_t;

  typedef struct packed {
    logic hi;
    logic lo_n;
    logic gnd;
  } znd_out_t;

  // P1/P2 swap HI and LO for a start-low lane; HI and LO can never coincide.
  function automatic znd_out_t decode_lane(lane_state_e st, logic start_lo);
    znd_out_t o;
    o.hi   = 1'b0;
    o.lo_n = 1'b1;
    o.gnd  = 1'b0;
    case (st)
      ST_P1: begin
        if (start_lo) o.lo_n = 1'b0;
        else          o.hi   = 1'b1;
      end
      ST_P2: begin
        if (start_lo) o.hi   = 1'b1;
        else          o.lo_n = 1'b0;
      end
      ST_P1_GND, ST_P2_GND, ST_HUSH: o.gnd = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pulse_gen_lane.sv
// pulse_gen_lane: one pulser lane (delay, count x {P1,GND,P2,GND}, hush).
//   hi_clk, rst        : clock, synchronous active-high reset
//   start              : one-cycle launch/restart strobe (E1)
//   enable, start_lo   : lane enable, polarity (1 = LO first)
//   delay              : start delay in ticks
//   hit_len, gnd_len   : phase lengths (0 treated as 1)
//   pulse_count        : full cycles per burst
//   hush_len           : GND hold after the last cycle
//   znd_*              : decoded switch drives
//   busy               : lane is not IDLE
module pulse_gen_lane
  import pulse_gen_pkg::*;
#(
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned HUSH_W = DEF_HUSH_W,
  parameter int unsigned DLY_W  = DEF_DLY_W
) (
  input  logic              hi_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              enable,
  input  logic              start_lo,
  input  logic [DLY_W-1:0]  delay,
  input  logic [LEN_W-1:0]  hit_len,
  input  logic [LEN_W-1:0]  gnd_len,
  input  logic [CNT_W-1:0]  pulse_count,
  input  logic [HUSH_W-1:0] hush_len,
  output logic              znd_hi,
  output logic              znd_lo_n,
  output logic              znd_gnd,
  output logic              znd_gnd_n,
  output logic              busy
);

  localparam int unsigned PH_W0 = (LEN_W > DLY_W) ? LEN_W : DLY_W;
  localparam int unsigned PH_W  = (PH_W0 > HUSH_W) ? PH_W0 : HUSH_W;
  localparam int unsigned PW1   = PH_W + 1;
  localparam int unsigned CW1   = CNT_W + 1;

  lane_state_e      state;
  logic [PH_W-1:0]  ph_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [PW1-1:0]   ph_len_c;
  logic             ph_last_c;
  logic             cyc_last_c;
  logic             active_c;
  znd_out_t         dec_c;

  assign active_c = enable && (pulse_count != '0);

  // Length of the current phase; one extra bit so cnt+1 never wraps.
  always_comb begin
    ph_len_c = PW1'(1);
    case (state)
      ST_DELAY:             ph_len_c = PW1'(delay);
      ST_P1, ST_P2:         ph_len_c = (hit_len == '0) ? PW1'(1) : PW1'(hit_len);
      ST_P1_GND, ST_P2_GND: ph_len_c = (gnd_len == '0) ? PW1'(1) : PW1'(gnd_len);
      ST_HUSH:              ph_len_c = PW1'(hush_len);
      default:              ph_len_c = PW1'(1);
    endcase
  end

  assign ph_last_c  = (PW1'(ph_cnt) + PW1'(1)) >= ph_len_c;
  assign cyc_last_c = (CW1'(cyc_cnt) + CW1'(1)) >= CW1'(pulse_count);

  // Lane FSM; a start strobe overrides whatever the lane was doing.
  always_ff @(posedge hi_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ph_cnt  <= '0;
      cyc_cnt <= '0;
    end else if (start) begin
      ph_cnt  <= '0;
      cyc_cnt <= '0;
      if (!active_c)          state <= ST_IDLE;
      else if (delay != '0)   state <= ST_DELAY;
      else                    state <= ST_P1;
    end else if (state != ST_IDLE) begin
      if (!ph_last_c) begin
        ph_cnt <= ph_cnt + PH_W'(1);
      end else begin
        ph_cnt <= '0;
        case (state)
          ST_DELAY:  state <= ST_P1;
          ST_P1:     state <= ST_P1_GND;
          ST_P1_GND: state <= ST_P2;
          ST_P2:     state <= ST_P2_GND;
          ST_P2_GND: begin
            if (!cyc_last_c) begin
              cyc_cnt <= cyc_cnt + CNT_W'(1);
              state   <= ST_P1;
            end else if (hush_len != '0) begin
              state <= ST_HUSH;
            end else begin
              state <= ST_IDLE;
            end
          end
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dec_c     = decode_lane(state, start_lo);
  assign znd_hi    = dec_c.hi;
  assign znd_lo_n  = dec_c.lo_n;
  assign znd_gnd   = dec_c.gnd;
  assign znd_gnd_n = ~dec_c.gnd;
  assign busy      = (state != ST_IDLE);

endmodule

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi: NCH-lane HI/GND/LO/GND burst pulser on hi_clk.
//   hi_clk, rst   : clock, synchronous active-high reset
//   i_sync        : trigger, rising edge used
//   i_enable, i_start_lo, i_delay : per-lane enable/polarity/delay
//   i_hit_len, i_gnd_len, i_pulse_count, i_hush_len : shared timing
//   o_znd_*       : per-lane switch drives (decoded lane state)
//   o_busy        : any lane not IDLE
//   o_done        : one-cycle pulse at burst end
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int unsigned NCH    = DEF_NCH,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned HUSH_W = DEF_HUSH_W,
  parameter int unsigned DLY_W  = DEF_DLY_W,
  parameter bit          RETRIG = 1'b0
) (
  input  logic                 hi_clk,
  input  logic                 rst,
  input  logic                 i_sync,
  input  logic [NCH-1:0]       i_enable,
  input  logic [NCH-1:0]       i_start_lo,
  input  logic [NCH*DLY_W-1:0] i_delay,
  input  logic [LEN_W-1:0]     i_hit_len,
  input  logic [LEN_W-1:0]     i_gnd_len,
  input  logic [CNT_W-1:0]     i_pulse_count,
  input  logic [HUSH_W-1:0]    i_hush_len,
  output logic [NCH-1:0]       o_znd_hi,
  output logic [NCH-1:0]       o_znd_lo_n,
  output logic [NCH-1:0]       o_znd_gnd,
  output logic [NCH-1:0]       o_znd_gnd_n,
  output logic                 o_busy,
  output logic                 o_done
);

  shadow_cfg_t          shadow;
  logic [NCH-1:0]       sh_enable;
  logic [NCH-1:0]       sh_start_lo;
  logic [NCH*DLY_W-1:0] sh_delay;
  logic                 prev_sync;
  logic                 start_q;
  logic                 busy_q;
  logic                 sync_rise_c;
  logic                 accept_c;
  logic                 any_active_c;
  logic [NCH-1:0]       lane_busy;

  // A launch still pending in start_q counts as busy for retrigger gating.
  assign sync_rise_c  = i_sync & ~prev_sync;
  assign accept_c     = sync_rise_c && (RETRIG || !(o_busy || start_q));
  assign any_active_c = (|sh_enable) && (shadow.pulse_count != '0);
  assign o_busy       = |lane_busy;

  // Sync detect, shadow capture, launch strobe and burst-complete pulse.
  always_ff @(posedge hi_clk) begin
    if (rst) begin
      prev_sync   <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      o_done      <= 1'b0;
      shadow      <= '0;
      sh_enable   <= '0;
      sh_start_lo <= '0;
      sh_delay    <= '0;
    end else begin
      prev_sync <= i_sync;
      start_q   <= accept_c;
      if (accept_c) begin
        shadow.hit_len     <= DEF_LEN_W'(i_hit_len);
        shadow.gnd_len     <= DEF_LEN_W'(i_gnd_len);
        shadow.pulse_count <= DEF_CNT_W'(i_pulse_count);
        shadow.hush_len    <= DEF_HUSH_W'(i_hush_len);
        sh_enable          <= i_enable;
        sh_start_lo        <= i_start_lo;
        sh_delay           <= i_delay;
      end
      // Launch cycle: an empty burst completes at once, and the busy
      // history is cleared so an aborted burst never reports done.
      if (start_q) begin
        busy_q <= 1'b0;
        o_done <= ~any_active_c;
      end else begin
        busy_q <= o_busy;
        o_done <= busy_q & ~o_busy;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    pulse_gen_lane #(
      .LEN_W  (LEN_W),
      .CNT_W  (CNT_W),
      .HUSH_W (HUSH_W),
      .DLY_W  (DLY_W)
    ) u_lane (
      .hi_clk      (hi_clk),
      .rst         (rst),
      .start       (start_q),
      .enable      (sh_enable[k]),
      .start_lo    (sh_start_lo[k]),
      .delay       (sh_delay[k*DLY_W +: DLY_W]),
      .hit_len     (LEN_W'(shadow.hit_len)),
      .gnd_len     (LEN_W'(shadow.gnd_len)),
      .pulse_count (CNT_W'(shadow.pulse_count)),
      .hush_len    (HUSH_W'(shadow.hush_len)),
      .znd_hi      (o_znd_hi[k]),
      .znd_lo_n    (o_znd_lo_n[k]),
      .znd_gnd     (o_znd_gnd[k]),
      .znd_gnd_n   (o_znd_gnd_n[k]),
      .busy        (lane_busy[k])
    );
  end

endmodule
